lsu_ctrl: RTL

Load/store unit sitting between the RV32I core's memory stage and the word-addressed, byte-masked memory array; it acts as the initiator that drives that memory's address, write-data, write-enable and byte-mask inputs. It accepts one load or store request at a time from the core over a valid/ready handshake. For stores it formats the data and byte mask by size and offset; for loads it extracts, aligns and sign- or zero-extends the read data. Misaligned or illegal accesses are rejected with an error response and never reach memory.

---
 rtl/lsu_pkg.sv | 15 +
 rtl/lsu_load_align.sv | 14 +
 rtl/lsu_ctrl.sv | 92 +++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM states and access-legality helpers for the load/store unit
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} lsu_state_t;
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    return (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
  endfunction
  function automatic logic is_illegal(input logic we, input logic [2:0] f3);
    return we ? (f3[2] || f3[1:0] == 2'b11) : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
  endfunction
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: extracts the addressed byte/halfword from a read word and sign- or zero-extends it
module lsu_load_align import lsu_pkg::*; (
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  output logic [31:0] result
);
  logic [31:0] sh;
  assign sh = rdata >> {off, 3'b000};
  assign result = funct3 == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
                  funct3 == F3_BU ? {24'b0, sh[7:0]} :
                  funct3 == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
                  funct3 == F3_HU ? {16'b0, sh[15:0]} : rdata;
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store unit driving a word-addressed, byte-masked memory
module lsu_ctrl import lsu_pkg::*; #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_wr,
  output logic [3:0]        mem_mask,
  input  logic [31:0]       mem_rdata
);
  lsu_state_t  state;
  logic [2:0]  f3;
  logic [1:0]  off;
  logic        we;
  logic [1:0]  req_off;
  logic        req_err;
  logic [3:0]  st_mask;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;
  logic        unused_hi;
  assign req_off   = req_addr[1:0];
  assign req_err   = is_misaligned(req_funct3, req_off) || is_illegal(req_we, req_funct3);
  assign st_mask   = req_funct3 == F3_B ? 4'b0001 << req_off :
                     req_funct3 == F3_H ? 4'b0011 << req_off : 4'b1111;
  assign st_wdata  = req_funct3 == F3_B ? {4{req_wdata[7:0]}} :
                     req_funct3 == F3_H ? {2{req_wdata[15:0]}} : req_wdata;
  assign unused_hi = ^req_addr[31:ADDR_W+2];
  lsu_load_align u_align (
    .funct3 (f3),
    .off    (off),
    .rdata  (mem_rdata),
    .result (ld_data)
  );
  // request/access/response sequencing with every output registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wr     <= 1'b0;
      mem_mask   <= '0;
      f3         <= '0;
      off        <= '0;
      we         <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          f3         <= req_funct3;
          off        <= req_off;
          we         <= req_we;
          mem_addr   <= req_addr[ADDR_W+1:2];
          mem_wdata  <= st_wdata;
          mem_mask   <= (req_we && !req_err) ? st_mask : 4'b0000;
          mem_wr     <= req_we && !req_err;
          req_ready  <= 1'b0;
          resp_err   <= req_err;
          resp_rdata <= '0;
          resp_valid <= req_err;
          state      <= req_err ? RESP : ACCESS;
        end
        ACCESS: begin
          mem_wr     <= 1'b0;
          mem_mask   <= '0;
          resp_valid <= 1'b1;
          resp_rdata <= we ? 32'b0 : ld_data;
          state      <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
